// File: rtl/lsu_dmem_ctrl.sv
// Load/store front-end for the data-memory req/ready handshake; one access in flight, any memory latency >= 1.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses respond with err 01 instead of issuing.
module lsu_dmem_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_wb,
    output logic [1:0]  out_err,
    output logic [31:0] out_badaddr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    // Data-memory access modes shared with the memory side.
    localparam logic [2:0] DM_LB  = 3'd0;
    localparam logic [2:0] DM_LH  = 3'd1;
    localparam logic [2:0] DM_LW  = 3'd2;
    localparam logic [2:0] DM_LBU = 3'd3;
    localparam logic [2:0] DM_LHU = 3'd4;
    localparam logic [2:0] DM_SB  = 3'd5;
    localparam logic [2:0] DM_SH  = 3'd6;
    localparam logic [2:0] DM_SW  = 3'd7;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_we;
    logic [2:0]    r_mem_mode;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_out_rdata;
    logic [4:0]    r_out_rd;
    logic          r_out_wb;
    logic [1:0]    r_out_err;
    logic [31:0]   r_out_badaddr;

    logic [2:0]    w_mode;
    logic          w_fn_illegal;
    logic          w_fault;
    logic          w_misalign;

    always_comb begin
        w_mode       = DM_LB;
        w_fn_illegal = 1'b0;
        if (in_we) begin
            case (in_funct3)
                3'b000:  w_mode = DM_SB;
                3'b001:  w_mode = DM_SH;
                3'b010:  w_mode = DM_SW;
                default: w_fn_illegal = 1'b1;
            endcase
        end else begin
            case (in_funct3)
                3'b000:  w_mode = DM_LB;
                3'b001:  w_mode = DM_LH;
                3'b010:  w_mode = DM_LW;
                3'b100:  w_mode = DM_LBU;
                3'b101:  w_mode = DM_LHU;
                default: w_fn_illegal = 1'b1;
            endcase
        end
    end

    assign w_fault = w_fn_illegal | (in_addr >= 32'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (((w_mode == DM_LH) || (w_mode == DM_LHU) || (w_mode == DM_SH)) && in_addr[0])
                      || (((w_mode == DM_LW) || (w_mode == DM_SW)) && (in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Request drops in the ready cycle so a single-cycle memory never sees a second access.
    assign mem_req     = !rst && (r_state == S_WAIT) && !mem_ready;
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_RESP);
    assign mem_we      = r_mem_we;
    assign mem_mode    = r_mem_mode;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign out_rdata   = r_out_rdata;
    assign out_rd      = r_out_rd;
    assign out_wb      = r_out_wb;
    assign out_err     = r_out_err;
    assign out_badaddr = r_out_badaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_mode    <= 3'd0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_out_rdata   <= 32'd0;
            r_out_rd      <= 5'd0;
            r_out_wb      <= 1'b0;
            r_out_err     <= ERR_OK;
            r_out_badaddr <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mem_we    <= in_we;
                        r_mem_mode  <= w_mode;
                        r_mem_addr  <= in_addr;
                        r_mem_wdata <= in_wdata;
                        r_out_rd    <= in_rd;
                        r_wait_cnt  <= '0;
                        if (w_fault || w_misalign) begin
                            r_out_err     <= w_fault ? ERR_FAULT : ERR_ALIGN;
                            r_out_badaddr <= in_addr;
                            r_out_rdata   <= 32'd0;
                            r_out_wb      <= 1'b0;
                            r_state       <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_out_rdata   <= r_mem_we ? 32'd0 : mem_rdata;
                        r_out_wb      <= !r_mem_we;
                        r_out_err     <= ERR_OK;
                        r_out_badaddr <= 32'd0;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if ((TIMEOUT != 0) && (r_wait_cnt == CW'(TIMEOUT - 1))) begin
                            r_out_rdata   <= 32'd0;
                            r_out_wb      <= 1'b0;
                            r_out_err     <= ERR_TMO;
                            r_out_badaddr <= r_mem_addr;
                            r_state       <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array reference model plus a latency-programmable memory responder.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_dmem_ctrl;
    localparam int TIMEOUT = 16;
    localparam logic [2:0] DM_LB  = 3'd0;
    localparam logic [2:0] DM_LH  = 3'd1;
    localparam logic [2:0] DM_LW  = 3'd2;
    localparam logic [2:0] DM_LBU = 3'd3;
    localparam logic [2:0] DM_LHU = 3'd4;
    localparam logic [2:0] DM_SB  = 3'd5;
    localparam logic [2:0] DM_SH  = 3'd6;
    localparam logic [2:0] DM_SW  = 3'd7;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_we = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_addr = 32'd0, in_wdata = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        out_valid, out_ready = 1'b0, out_wb;
    logic [31:0] out_rdata, out_badaddr;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;

    lsu_dmem_ctrl #(.TIMEOUT(TIMEOUT), .MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_wb(out_wb), .out_err(out_err), .out_badaddr(out_badaddr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr, wdata, rdata, badaddr;
        logic [4:0]  rd;
        logic        wb;
        logic [1:0]  err;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  ref_mem  [0:4095];
    logic [7:0]  stub_mem [0:4095];
    int          n_vec = 0, n_miss = 0;
    int          mem_lat = 1;
    int          req_cnt = 0;
    bit          tb_busy = 1'b0;
    logic [31:0] last_rdata = 32'd0, last_badaddr = 32'd0;
    logic [1:0]  last_err = 2'd0;
    logic        last_wb = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected response from the access rules, using a separate byte-array image of memory.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd, input bit never);
        exp_t e;
        logic [31:0] sz, base, v;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rd = rd;
        e.rdata = 32'd0; e.wb = 1'b0; e.err = 2'd0; e.badaddr = 32'd0;
        sz = 32'd1 << f3[1:0];
        if (we) e.mode = (f3 == 3'd0) ? DM_SB : (f3 == 3'd1) ? DM_SH : DM_SW;
        else    e.mode = (f3 == 3'd0) ? DM_LB : (f3 == 3'd1) ? DM_LH : (f3 == 3'd2) ? DM_LW
                       : (f3 == 3'd4) ? DM_LBU : DM_LHU;
        if ((we && f3 >= 3'd3) || (!we && (f3 == 3'd3 || f3 >= 3'd6)) || addr >= 32'd4096) e.err = 2'd2;
        else if (TRAP && (addr % sz) != 32'd0) e.err = 2'd1;
        else if (never) e.err = 2'd3;
        else begin
            base = addr - (addr % sz);
            if (we) begin
                for (int i = 0; i < int'(sz); i++) ref_mem[12'(base + 32'(i))] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < int'(sz); i++) v = v + (32'(ref_mem[12'(base + 32'(i))]) << (8*i));
                if (!f3[2] && sz < 32'd4 && v[8*int'(sz)-1]) v = v | (32'hFFFF_FFFF << (8*int'(sz)));
                e.rdata = v;
                e.wb = 1'b1;
            end
        end
        if (e.err != 2'd0) e.badaddr = addr;
        return e;
    endfunction

    // Memory responder: ready arrives mem_lat cycles after req is first seen; mem_lat 0 never answers.
    initial begin
        int  scnt;
        bit  fire;
        logic [31:0] sz, base, v;
        scnt = 0;
        for (int i = 0; i < 4096; i++) begin
            stub_mem[i] = 8'd0;
            ref_mem[i]  = 8'd0;
        end
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (rst || !mem_req) scnt = 0;
            else if (mem_lat != 0) begin
                scnt++;
                if (scnt == mem_lat) begin fire = 1'b1; scnt = 0; end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = 32'd0;
            if (fire) begin
                case (mem_mode)
                    DM_LB, DM_LBU, DM_SB: sz = 32'd1;
                    DM_LH, DM_LHU, DM_SH: sz = 32'd2;
                    default:              sz = 32'd4;
                endcase
                base = mem_addr & ~(sz - 32'd1);
                v = 32'd0;
                for (int i = 0; i < int'(sz); i++) begin
                    if (mem_we) stub_mem[12'(base + 32'(i))] = mem_wdata[8*i +: 8];
                    else v = v | (32'(stub_mem[12'(base + 32'(i))]) << (8*i));
                end
                if (mem_mode == DM_LB && v[7])  v = v | 32'hFFFF_FF00;
                if (mem_mode == DM_LH && v[15]) v = v | 32'hFFFF_0000;
                mem_rdata = mem_we ? 32'd0 : v;
                mem_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the head of the expected-response queue.
    initial begin
        exp_t f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", 32'(in_ready), 32'(!tb_busy));
                if (mem_req) begin
                    req_cnt++;
                    if (expq.size() == 0 || expq[0].err == 2'd1 || expq[0].err == 2'd2)
                        chk("mem_req_spurious", 32'(mem_req), 32'd0);
                    else begin
                        f = expq[0];
                        chk("mem_we", 32'(mem_we), 32'(f.we));
                        chk("mem_mode", 32'(mem_mode), 32'(f.mode));
                        chk("mem_addr", mem_addr, f.addr);
                        chk("mem_wdata", mem_wdata, f.wdata);
                    end
                end
                if (out_valid) begin
                    if (expq.size() == 0) chk("out_valid_spurious", 32'(out_valid), 32'd0);
                    else begin
                        f = expq[0];
                        chk("out_rdata", out_rdata, f.rdata);
                        chk("out_rd", 32'(out_rd), 32'(f.rd));
                        chk("out_wb", 32'(out_wb), 32'(f.wb));
                        chk("out_err", 32'(out_err), 32'(f.err));
                        chk("out_badaddr", out_badaddr, f.badaddr);
                        if (out_ready) begin
                            last_rdata = out_rdata; last_err = out_err;
                            last_wb = out_wb; last_badaddr = out_badaddr;
                            void'(expq.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int lowcyc);
        exp_t e;
        int   k, exp_k, exp_r;
        bit   seen;
        e = model(we, f3, addr, wdata, rd, mem_lat == 0);
        expq.push_back(e);
        exp_k = (e.err == 2'd1 || e.err == 2'd2) ? 1 : (e.err == 2'd3) ? TIMEOUT + 1 : mem_lat + 2;
        exp_r = (e.err == 2'd1 || e.err == 2'd2) ? 0 : (e.err == 2'd3) ? TIMEOUT : mem_lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_we = we; in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; tb_busy = 1'b1; req_cnt = 0;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            expq.delete();
        end else chk("resp_latency", 32'(k), 32'(exp_k));
        repeat (lowcyc) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tb_busy = 1'b0;
        chk("req_cycles", 32'(req_cnt), 32'(exp_r));
        $display("txn we=%0d f3=%0d addr=%h wdata=%h lat=%0d -> err=%0d wb=%0d rdata=%h cyc=%0d req=%0d",
                 we, f3, addr, wdata, mem_lat, last_err, last_wb, last_rdata, k, req_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_outs", {mem_addr | mem_wdata}, 32'd0);
        chk("rst_mem_ctl", 32'({mem_we, mem_mode}), 32'd0);
        chk("rst_out_data", out_rdata | out_badaddr, 32'd0);
        chk("rst_out_ctl", 32'({out_rd, out_wb, out_err}), 32'd0);

        mem_lat = 1;
        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1);
        chk("lit_lw_deadbeef", last_rdata, 32'hDEADBEEF);
        chk("lit_lw_wb", 32'(last_wb), 32'd1);

        do_op(1'b1, 3'b010, 32'h100, 32'h0, 5'd0, 1);
        do_op(1'b1, 3'b000, 32'h103, 32'h80, 5'd0, 1);
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1);
        chk("lit_lb", last_rdata, 32'hFFFFFF80);
        do_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1);
        chk("lit_lbu", last_rdata, 32'h00000080);
        do_op(1'b0, 3'b101, 32'h102, 32'h0, 5'd8, 1);
        chk("lit_lhu", last_rdata, 32'h00008000);

        do_op(1'b1, 3'b010, 32'hFFC, 32'h12345678, 5'd0, 1);
        do_op(1'b0, 3'b001, 32'hFFE, 32'h0, 5'd9, 1);
        chk("lit_lh_top", last_rdata, 32'h00001234);

        mem_lat = 3;
        do_op(1'b0, 3'b010, 32'h100, 32'hA5A5A5A5, 5'd10, 2);
        chk("lit_lat3_lw", last_rdata, 32'h80000000);

        mem_lat = 1;
        do_op(1'b0, 3'b010, 32'h102, 32'h0, 5'd11, 1);
        chk("lit_misalign_err", 32'(last_err), TRAP ? 32'd1 : 32'd0);
        chk("lit_misalign_data", TRAP ? last_badaddr : last_rdata, TRAP ? 32'h102 : 32'h80000000);
        do_op(1'b1, 3'b001, 32'h101, 32'hBEEF, 5'd0, 1);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd12, 1);
        do_op(1'b0, 3'b101, 32'hFFF, 32'h0, 5'd13, 1);

        do_op(1'b0, 3'b010, 32'h1000, 32'h0, 5'd14, 1);
        chk("lit_fault_err", 32'(last_err), 32'd2);
        chk("lit_fault_badaddr", last_badaddr, 32'h1000);
        do_op(1'b0, 3'b011, 32'h0, 32'h0, 5'd15, 1);
        chk("lit_illegal_ld_err", 32'(last_err), 32'd2);
        chk("lit_illegal_ld_wb", 32'(last_wb), 32'd0);
        do_op(1'b1, 3'b011, 32'h0, 32'h1, 5'd0, 1);
        do_op(1'b0, 3'b110, 32'h4, 32'h0, 5'd16, 1);

        // Never-ready memory: 16 request cycles, response in cycle N+17.
        mem_lat = 0;
        do_op(1'b0, 3'b010, 32'h200, 32'h0, 5'd17, 1);
        chk("lit_timeout_err", 32'(last_err), 32'd3);
        chk("lit_timeout_badaddr", last_badaddr, 32'h200);

        expq.push_back(model(1'b0, 3'b010, 32'h10, 32'h0, 5'd18, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'b010; in_addr = 32'h10; in_rd = 5'd18;
        @(posedge clk); #1;
        in_valid = 1'b0; tb_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; tb_busy = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        $display("txn reset during S_WAIT addr=%h", 32'h10);

        mem_lat = 1;
        do_op(1'b0, 3'b010, 32'hFFC, 32'h0, 5'd19, 1);
        chk("lit_after_rst", last_rdata, 32'h12345678);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
